// File: rtl/ibex_rvfi_trace_buffer_if.sv
// RVFI retirement port plus the outbound 32-bit trace stream of the trace buffer.
// master = the trace buffer itself, slave = the core/sink environment around it.
interface ibex_rvfi_trace_buffer_if;
    logic        rvfi_valid;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;

    logic        trace_valid_o;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        trace_ready_i;
    logic [15:0] overflow_cnt_o;

    modport master (
        input  rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_mode, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               trace_ready_i,
        output trace_valid_o, trace_data_o, trace_last_o, overflow_cnt_o
    );

    modport slave (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_intr, rvfi_mode, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
               trace_ready_i,
        input  trace_valid_o, trace_data_o, trace_last_o, overflow_cnt_o
    );
endinterface

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI record FIFO serialised into 2..4-word-tail trace records; header one cycle after push.
// Sink backpressure stalls the serializer; RVFI cannot stall, so pushes into a full FIFO are dropped and counted.
module ibex_rvfi_trace_buffer_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] cnt_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ibex_rvfi_trace_buffer_if.master bus
);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    typedef struct packed {
        logic [7:0]  drop_cnt;
        logic [1:0]  mode;
        logic        intr;
        logic        trap;
        logic [3:0]  wmask;
        logic [3:0]  rmask;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] mem_addr;
    } rec_t;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_INSN, S_RD, S_MEM} state_e;

    state_e          state_q, state_d;
    logic [7:0]      drop_q, drop_d;
    logic [15:0]     ovf_q, ovf_d;
    rec_t            wr_rec, head;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_cnt;
    logic            push_en, drop_en, pop_en, hs, more;
    logic            has_rd, has_mem, last_word;
    logic [2:0]      n_follow;
    logic            trace_vld;
    logic [31:0]     trace_dat;

    // Fullness is taken from the registered pointers, so a same-cycle pop never frees a slot.
    assign push_en = bus.rvfi_valid && !fifo_full;
    assign drop_en = bus.rvfi_valid && fifo_full;

    always_comb begin
        wr_rec          = '0;
        wr_rec.drop_cnt = drop_q;
        wr_rec.mode     = bus.rvfi_mode;
        wr_rec.intr     = bus.rvfi_intr;
        wr_rec.trap     = bus.rvfi_trap;
        wr_rec.wmask    = bus.rvfi_mem_wmask;
        wr_rec.rmask    = bus.rvfi_mem_rmask;
        wr_rec.rd_addr  = bus.rvfi_rd_addr;
        wr_rec.rd_wdata = bus.rvfi_rd_wdata;
        wr_rec.pc       = bus.rvfi_pc_rdata;
        wr_rec.insn     = bus.rvfi_insn;
        wr_rec.mem_addr = bus.rvfi_mem_addr;
    end

    ibex_rvfi_trace_buffer_fifo #(
        .Width ($bits(rec_t)),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_en),
        .wdata_i (wr_rec),
        .pop_i   (pop_en),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt)
    );

    assign has_rd    = (head.rd_addr != 5'd0);
    assign has_mem   = ((head.rmask | head.wmask) != 4'd0);
    assign n_follow  = 3'd2 + {2'b00, has_rd} + {2'b00, has_mem};
    assign trace_vld = (state_q != S_IDLE);
    assign hs        = trace_vld && bus.trace_ready_i;
    assign pop_en    = hs && last_word;
    assign more      = (fifo_cnt > CntW'(1)) || push_en;

    always_comb begin
        last_word = 1'b0;
        trace_dat = 32'd0;
        case (state_q)
            S_HDR:  trace_dat = {4'hA, head.drop_cnt, head.mode, head.intr, head.trap,
                                 head.wmask, head.rmask, head.rd_addr, n_follow};
            S_PC:   trace_dat = head.pc;
            S_INSN: begin
                trace_dat = head.insn;
                last_word = !has_rd && !has_mem;
            end
            S_RD: begin
                trace_dat = head.rd_wdata;
                last_word = !has_mem;
            end
            S_MEM: begin
                trace_dat = head.mem_addr;
                last_word = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!fifo_empty || push_en) state_d = S_HDR;
            S_HDR:  if (hs) state_d = S_PC;
            S_PC:   if (hs) state_d = S_INSN;
            S_INSN: if (hs) state_d = has_rd ? S_RD : (has_mem ? S_MEM : S_IDLE);
            S_RD:   if (hs) state_d = has_mem ? S_MEM : S_IDLE;
            S_MEM:  if (hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Back-to-back records: go straight to the next header with no idle bubble.
        if (pop_en) state_d = more ? S_HDR : S_IDLE;
    end

    always_comb begin
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (push_en) begin
            drop_d = 8'd0;
        end else if (drop_en) begin
            if (drop_q != 8'hFF)     drop_d = drop_q + 8'd1;
            if (ovf_q  != 16'hFFFF) ovf_d  = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            drop_q  <= 8'd0;
            ovf_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.trace_valid_o  = trace_vld;
    assign bus.trace_data_o   = trace_dat;
    assign bus.trace_last_o   = last_word;
    assign bus.overflow_cnt_o = ovf_q;
endmodule

// File: doc/ibex_rvfi_trace_buffer.md
# ibex_rvfi_trace_buffer

Captures each retired-instruction record from the core's RVFI port into a small record FIFO and drains it as a variable-length sequence of 32-bit words on a valid/ready trace stream for an off-core trace sink. It sits directly downstream of the core's RVFI outputs, in parallel with the simulation tracer, and is synthesizable. RVFI cannot be stalled, so records that arrive when the FIFO is full are dropped and counted.

## Interface
- Depth, 4, record FIFO depth; power of two, 2..16.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- rvfi_valid  in  1  a record retires this cycle.
- rvfi_insn  in  32  instruction word.
- rvfi_trap, rvfi_intr  in  1 each  trap / first-instruction-of-handler flags.
- rvfi_mode  in  2  privilege mode.
- rvfi_rd_addr  in  5  destination register; 0 means no write.
- rvfi_rd_wdata  in  32  destination write data.
- rvfi_pc_rdata  in  32  PC of the instruction.
- rvfi_mem_addr  in  32  memory access address.
- rvfi_mem_rmask, rvfi_mem_wmask  in  4 each  byte read and write masks.
- trace_valid_o  out  1  trace word valid.
- trace_data_o  out  32  trace word.
- trace_last_o  out  1  last word of the current record.
- trace_ready_i  in  1  sink accepts the word.
- overflow_cnt_o  out  16  total dropped records; saturates at 16'hFFFF.

## Operation
- Record layout, words in this order:
  - Header (always sent), with these fields:
    - [31:28] = 4'hA.
    - [27:20] = drop_cnt: the number of records dropped immediately before this one, saturating at 255.
    - [19:18] = mode, [17] = intr, [16] = trap.
    - [15:12] = wmask, [11:8] = rmask, [7:3] = rd_addr.
    - [2:0] = the number of words that follow the header, from 2 to 4.
  - PC (always sent).
  - INSN (always sent).
  - RD: sent only when rd_addr != 0.
  - MEM: rvfi_mem_addr, sent only when (rmask | wmask) != 0.
- Push: when rvfi_valid is high and occupancy < Depth, the record is written at the tail.
  - The header's drop_cnt field takes the current value of the internal drop counter.
  - The drop counter is then cleared.
- Drop: when rvfi_valid is high and occupancy == Depth, the record is discarded.
  - The internal drop counter increments, saturating at 255.
  - overflow_cnt_o increments, saturating at 16'hFFFF.
- Fullness is judged on occupancy at the start of the cycle. A record that finishes draining in the same cycle does not free a slot for a concurrent push; that push is dropped.
- Serializer state machine, with states IDLE, HDR, PC, INSN, RD and MEM:
  - IDLE: leaves for HDR when the FIFO is non-empty.
  - Each state other than IDLE advances only on a handshake (trace_valid_o && trace_ready_i).
  - Order is HDR -> PC -> INSN -> RD -> MEM, skipping RD or MEM when that word is absent.
  - On the handshake of the last word, the record is popped. The FSM then goes to HDR if another record is present, otherwise to IDLE.
- trace_valid_o is high in every state except IDLE. trace_last_o is high only on the final word of a record.
- trace_data_o is taken from the FIFO head selected by the state.
- Pointer wrap-around: pointers are log2(Depth) bits plus one wrap bit. Full means the index bits are equal and the wrap bits differ; empty means the pointers are equal.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): FIFO empty, FSM in IDLE, drop counter 0.
  - Outputs: trace_valid_o = 0, trace_last_o = 0, trace_data_o = 0, overflow_cnt_o = 0.
- Reset asserted mid-record: the partial record is abandoned and no word is re-sent after reset.
- Latency: a record pushed in cycle N presents its header in cycle N+1 if the FSM is idle.
- Throughput is one word per cycle with no gap between records when trace_ready_i is held high.
- Stream rule: once trace_valid_o is high, trace_valid_o, trace_data_o and trace_last_o are held stable until the handshake. trace_valid_o never depends combinationally on trace_ready_i.
- One push and one pop may occur in the same cycle, and occupancy is then unchanged.

## Test plan
- Single ALU record, PC 0x80, insn 0x00500093, rd = 1, wdata 5, ready held high:
  - Words appear from cycle N+1: header 0xA0000_0_0B (rd = 1, count = 3), then 0x80, 0x00500093, 0x5.
  - last is high on the fourth word.
- Store with rd = 0, wmask 0xF, addr 0x1000:
  - Header [15:12] = 0xF, count = 3.
  - Sequence is HDR, PC, INSN, 0x1000, with the RD word skipped.
- Overflow: Depth = 4, trace_ready_i held low, 7 consecutive valid records:
  - 4 records are stored and overflow_cnt_o = 3.
  - After ready is raised, the header of the first record pushed after the overflow carries drop_cnt = 3.
- Back-pressure: trace_ready_i toggles on alternate cycles during a 5-word load record.
  - Data holds stable while ready is low.
  - All 5 words are delivered in order and last asserts once.
- Full with concurrent drain: the FIFO is full and the last-word handshake lands in the same cycle as rvfi_valid.
  - The new record is dropped, overflow_cnt_o increments, and occupancy becomes 3.
- Reset mid-record: rst_ni is asserted during the PC word.
  - All outputs go to 0 immediately.
  - After release with no input, trace_valid_o stays 0.
